// File: rtl/handshake_skid_buffer.sv
// Two-entry skid buffer / register slice between a valid/ready producer and
// its consumer. ready_o and valid_o come straight from flops, which breaks the
// combinational ready path. The buffer sustains one beat per cycle with one
// cycle of latency.
//
// state | meaning
// ------+-----------------------------------------------------------
// EMPTY | no beat held; valid_o=0, ready_o=1
// BUSY  | one beat held in out_reg; valid_o=1, ready_o=1
// FULL  | out_reg holds the older beat, skid_reg the newer; ready_o=0
module handshake_skid_buffer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              ready_i,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [DATA_W-1:0] out_reg;
  logic [DATA_W-1:0] skid_reg;
  logic              in_fire;
  logic              out_fire;
  logic              load_out_in;
  logic              load_out_skid;
  logic              load_skid;

  assign in_fire   = valid_i & ready_o;
  assign out_fire  = valid_o & ready_i;
  assign data_o    = out_reg;
  assign occupancy = state_q;

  // Next-state and storage-load decisions from the current state and handshakes.
  always_comb begin
    state_d       = state_q;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          load_out_in = 1'b1;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          load_out_in = 1'b1;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_d   = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // ready_o is low here, so no beat can arrive in this state.
        if (out_fire) begin
          load_out_skid = 1'b1;
          state_d       = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State, registered handshake outputs and the two data entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      ready_o  <= 1'b0;
      valid_o  <= 1'b0;
      out_reg  <= '0;
      skid_reg <= '0;
    end else begin
      state_q <= state_d;
      ready_o <= (state_d != FULL);
      valid_o <= (state_d != EMPTY);
      if (load_out_in) begin
        out_reg <= data_i;
      end else if (load_out_skid) begin
        out_reg <= skid_reg;
      end
      if (load_skid) begin
        skid_reg <= data_i;
      end
    end
  end

endmodule

// File: tb/tb_handshake_skid_buffer.sv
// Directed bench for handshake_skid_buffer: reset, streaming, skid, hold
// under backpressure, drain and reset while full.
module tb_handshake_skid_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_i;
  logic [7:0] data_i;
  logic       ready_o;
  logic       valid_o;
  logic [7:0] data_o;
  logic       ready_i;
  logic [1:0] occupancy;

  int total = 0;
  int bad   = 0;

  handshake_skid_buffer #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_i   (valid_i),
    .data_i    (data_i),
    .ready_o   (ready_o),
    .valid_o   (valid_o),
    .data_o    (data_o),
    .ready_i   (ready_i),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance through one rising edge and return on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all(input string tag, input logic v, input logic r,
                         input logic [7:0] d, input logic [1:0] occ);
    chk({tag, ".valid_o"}, 32'(valid_o), 32'(v));
    chk({tag, ".ready_o"}, 32'(ready_o), 32'(r));
    chk({tag, ".data_o"}, 32'(data_o), 32'(d));
    chk({tag, ".occ"}, 32'(occupancy), 32'(occ));
  endtask

  initial begin
    rst     = 1'b1;
    valid_i = 1'b1;
    data_i  = 8'hAA;
    ready_i = 1'b0;
    @(negedge clk);

    // reset with a beat presented: dropped
    repeat (3) step();
    chk_all("reset", 1'b0, 1'b0, 8'h00, 2'd0);

    rst     = 1'b0;
    valid_i = 1'b0;
    step();
    chk("rst_rel.ready_o", 32'(ready_o), 32'd1);
    chk("rst_rel.valid_o", 32'(valid_o), 32'd0);

    // streaming 1..8 with consumer always ready
    ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      valid_i = 1'b1;
      data_i  = 8'(i);
      step();
      chk_all($sformatf("stream%0d", i), 1'b1, 1'b1, 8'(i), 2'd1);
    end
    valid_i = 1'b0;
    step();
    chk("stream_end.valid_o", 32'(valid_o), 32'd0);
    chk("stream_end.occ", 32'(occupancy), 32'd0);

    // skid: BUSY with 8'h11, consumer stalls while 8'h22 arrives
    valid_i = 1'b1;
    data_i  = 8'h11;
    ready_i = 1'b0;
    step();
    chk_all("busy11", 1'b1, 1'b1, 8'h11, 2'd1);
    data_i = 8'h22;
    step();
    chk_all("full", 1'b1, 1'b0, 8'h11, 2'd2);

    // backpressure: 8'h33 offered but never accepted
    data_i = 8'h33;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_all($sformatf("hold%0d", i), 1'b1, 1'b0, 8'h11, 2'd2);
    end

    // drain: 8'h11 was shown, then 8'h22, then empty
    valid_i = 1'b0;
    ready_i = 1'b1;
    step();
    chk_all("drain22", 1'b1, 1'b1, 8'h22, 2'd1);
    step();
    chk("drain_end.valid_o", 32'(valid_o), 32'd0);
    chk("drain_end.occ", 32'(occupancy), 32'd0);
    chk("drain_end.ready_o", 32'(ready_o), 32'd1);

    // refill to FULL, then reset
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i  = 8'h44;
    step();
    data_i = 8'h55;
    step();
    chk_all("refill", 1'b1, 1'b0, 8'h44, 2'd2);
    rst     = 1'b1;
    valid_i = 1'b0;
    step();
    chk_all("rst_full", 1'b0, 1'b0, 8'h00, 2'd0);
    rst     = 1'b0;
    ready_i = 1'b1;
    step();
    chk_all("post_rst", 1'b0, 1'b1, 8'h00, 2'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_all($sformatf("no_stale%0d", i), 1'b0, 1'b1, 8'h00, 2'd0);
    end

    // fresh beat after reset goes through normally
    valid_i = 1'b1;
    data_i  = 8'h66;
    step();
    valid_i = 1'b0;
    chk_all("fresh66", 1'b1, 1'b1, 8'h66, 2'd1);
    step();
    chk("fresh_end.valid_o", 32'(valid_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/handshake_skid_buffer.md
Name: handshake_skid_buffer

Overview:
- Two-entry skid buffer (register slice) that sits directly downstream of the valid/ready handshake stage and feeds the next consumer.
- It breaks the combinational ready path: ready_o and valid_o both come straight from flops.
- Full throughput of one transfer per cycle, one cycle of latency, strict in-order delivery.
- Absorbs one extra beat when the consumer stalls on the same cycle a beat arrives.

Parameters:
- DATA_W, default 8: width of data_i, data_o and both internal entries.

Ports:
- clk, input, 1: the single clock; all flops update on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- valid_i, input, 1: upstream beat valid.
- data_i, input, DATA_W: upstream beat payload.
- ready_o, output, 1: buffer can accept a beat this cycle; driven directly from a flop.
- valid_o, output, 1: downstream beat valid; driven directly from a flop.
- data_o, output, DATA_W: downstream beat payload; driven directly from the output entry flop.
- ready_i, input, 1: downstream accepts the beat this cycle.
- occupancy, output, 2: number of held beats (0, 1 or 2).

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high, sampled only on the clk rising edge.
- Definitions: in_fire = valid_i & ready_o; out_fire = valid_o & ready_i.
- Storage: out_reg (drives data_o) and skid_reg.
- State machine: EMPTY (0 beats), BUSY (1 beat, in out_reg), FULL (2 beats; out_reg holds the older beat, skid_reg the newer).
- Reset (rst=1 at an edge):
  - state=EMPTY; valid_o=0; ready_o=0; data_o=0; skid_reg=0; occupancy=0.
  - Any beat presented during reset is dropped.
  - ready_o rises on the first edge with rst=0.
- Registered outputs:
  - ready_o is the flop of (next_state != FULL).
  - valid_o is the flop of (next_state != EMPTY).
  - occupancy encodes the state: EMPTY=0, BUSY=1, FULL=2.
- Transitions from EMPTY:
  - in_fire: out_reg<=data_i, go to BUSY.
  - Otherwise: stay in EMPTY.
- Transitions from BUSY:
  - in_fire & out_fire: out_reg<=data_i, stay in BUSY (streaming).
  - in_fire & !out_fire: skid_reg<=data_i, go to FULL; ready_o=0 from the next cycle.
  - !in_fire & out_fire: go to EMPTY.
  - Neither: hold.
- Transitions from FULL:
  - out_fire: out_reg<=skid_reg, go to BUSY; ready_o=1 from the next cycle.
  - No out_fire: hold.
  - in_fire cannot occur because ready_o=0.
- Latency and ordering:
  - A beat accepted at edge N appears on data_o with valid_o=1 after edge N.
  - Sustained rate is 1 beat/cycle while ready_i=1.
  - Beats leave in acceptance order; none is duplicated or lost.
- Output stability:
  - Once valid_o=1, it stays 1 and data_o stays constant until out_fire.
  - valid_o never deasserts without out_fire or rst.
- valid_i with ready_o=0: ignored; no state or storage change. Upstream holds the beat.
- ready_i with valid_o=0: no effect.
- Storage not being written holds its value; skid_reg contents are don't-care outside FULL.
- Reset mid-operation: all held beats (BUSY or FULL) are discarded. The outputs return to their reset values on that edge.

Test Plan:
- Reset, then idle:
  - rst=1 for 3 cycles with valid_i=1, data_i=8'hAA → valid_o=0, ready_o=0, data_o=0, occupancy=0.
  - First edge with rst=0 → ready_o=1, valid_o stays 0.
- Streaming:
  - ready_i=1; valid_i=1 for 8 cycles with data_i=1..8 → valid_o=1 from the cycle after the first accept.
  - data_o shows 1..8 on consecutive cycles; occupancy stays 1; ready_o never drops.
- Skid:
  - BUSY holding 8'h11, ready_i=0, valid_i=1 with data_i=8'h22 → FULL, ready_o=0, occupancy=2, data_o=8'h11 held.
  - ready_i=1 → data_o=8'h22 on the next cycle, ready_o=1, occupancy=1.
- Backpressure hold: FULL with ready_i=0 for 10 cycles and valid_i=1 carrying 8'h33 → no state change, 8'h33 never accepted, data_o stays stable.
- Drain:
  - After the skid case, valid_i=0 and ready_i=1 → 8'h11, then 8'h22, then valid_o=0, occupancy=0.
- Reset in FULL: rst=1 for one edge → valid_o=0, occupancy=0, data_o=0. Prior contents never appear on data_o afterwards.
